// File: rtl/random_pulser_pkg.sv
// Shared types and constants for the random pulser array.
// State encoding for the per-channel oneshot, LFSR geometry and seed derivation.
package random_pulser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DEAD   = 2'd2
  } state_t;

  localparam int LFSR_WIDTH = 16;

  // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  // Channel n seed: base XOR n*0x1F35; zero is remapped because the LFSR would lock up.
  function automatic logic [LFSR_WIDTH-1:0] channel_seed(input logic [LFSR_WIDTH-1:0] base,
                                                         input int n);
    logic [LFSR_WIDTH-1:0] s;
    s = base ^ LFSR_WIDTH'(n * 32'h1F35);
    if (s == '0) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/pulser_channel.sv
// One pulser channel: LFSR, rate compare, oneshot with dead time, and
// saturating accepted/lost counters.
// Build option RANDOM_PULSER_RETRIGGER_EN: a hit during ACTIVE restarts the
// pulse and counts as accepted instead of lost.
//
// Handshake note: there is no valid/ready flow here; pulse is a one-cycle
// strobe and the oneshot consumes every strobe it sees, either accepting it
// (IDLE, or ACTIVE when retrigger is built in) or counting it as lost.
module pulser_channel
  import random_pulser_pkg::*;
#(
  parameter int THRESH_WIDTH = 8,
  parameter int PULSE_LEN    = 10,
  parameter int DEAD_TIME    = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [THRESH_WIDTH-1:0] thresh,
  input  logic                    count_clr,
  output logic                    pulse,
  output logic                    pout,
  output logic [COUNT_WIDTH-1:0]  accepted,
  output logic [COUNT_WIDTH-1:0]  lost,
  output state_t                  state
);

`ifdef RANDOM_PULSER_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  localparam int TIMER_MAX = (PULSE_LEN > DEAD_TIME) ? PULSE_LEN : DEAD_TIME;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] DEAD_LOAD  = TIMER_W'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic                  hit;
  logic [TIMER_W-1:0]    timer;
  logic                  acc_evt;
  logic                  lost_evt;

  assign lfsr_next = {1'b0, lfsr[LFSR_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  assign hit       = enable && (lfsr[LFSR_WIDTH-1 -: THRESH_WIDTH] < thresh);

  // A strobe is accepted when idle (or while active with retrigger); any other strobe is lost.
  assign acc_evt  = pulse && ((state == ST_IDLE) || (RETRIGGER && (state == ST_ACTIVE)));
  assign lost_evt = pulse && !acc_evt;

  // LFSR steps only while enabled; raw hit is registered into the one-cycle pulse strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr  <= SEED;
      pulse <= 1'b0;
    end else begin
      if (enable) lfsr <= lfsr_next;
      pulse <= hit;
    end
  end

  // Oneshot FSM: IDLE -> ACTIVE for PULSE_LEN cycles -> DEAD for DEAD_TIME cycles -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      timer <= '0;
      pout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pulse) begin
            state <= ST_ACTIVE;
            timer <= PULSE_LOAD;
            pout  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (RETRIGGER && pulse) begin
            timer <= PULSE_LOAD;
          end else if (timer == '0) begin
            pout <= 1'b0;
            if (DEAD_TIME == 0) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DEAD;
              timer <= DEAD_LOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DEAD: begin
          if (timer == '0) state <= ST_IDLE;
          else             timer <= timer - 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
          pout  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating event counters; a clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      accepted <= '0;
      lost     <= '0;
    end else if (count_clr) begin
      accepted <= '0;
      lost     <= '0;
    end else begin
      if (acc_evt && (accepted != '1))  accepted <= accepted + COUNT_WIDTH'(1);
      if (lost_evt && (lost != '1))     lost     <= lost + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/random_pulser_array.sv
// Multi-channel pseudo-random pulse generator top: slices the threshold bus,
// instantiates one pulser_channel per channel and muxes the event counters.
// Build option RANDOM_PULSER_RETRIGGER_EN enables retriggerable oneshots.
// dbg_state carries each channel's FSM state (2 bits per channel) for observation.
module random_pulser_array
  import random_pulser_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int THRESH_WIDTH = 8,
  parameter int PULSE_LEN    = 10,
  parameter int DEAD_TIME    = 4,
  parameter int COUNT_WIDTH  = 16,
  parameter logic [LFSR_WIDTH-1:0] SEED_BASE = 16'hACE1,
  localparam int SEL_W = $clog2(2 * CHANNELS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [CHANNELS*THRESH_WIDTH-1:0] thresh,
  input  logic                             count_clr,
  input  logic [SEL_W-1:0]                 cnt_sel,
  output logic [CHANNELS-1:0]              pulse,
  output logic [CHANNELS-1:0]              pout,
  output logic [COUNT_WIDTH-1:0]           cnt_out,
  output logic [2*CHANNELS-1:0]            dbg_state
);

  logic [COUNT_WIDTH-1:0] acc_cnt  [CHANNELS];
  logic [COUNT_WIDTH-1:0] lost_cnt [CHANNELS];
  logic [COUNT_WIDTH-1:0] sel_val;
  logic [31:0]            sel_wide;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t ch_state;

    pulser_channel #(
      .THRESH_WIDTH(THRESH_WIDTH),
      .PULSE_LEN   (PULSE_LEN),
      .DEAD_TIME   (DEAD_TIME),
      .COUNT_WIDTH (COUNT_WIDTH),
      .SEED        (channel_seed(SEED_BASE, g))
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .thresh   (thresh[g*THRESH_WIDTH +: THRESH_WIDTH]),
      .count_clr(count_clr),
      .pulse    (pulse[g]),
      .pout     (pout[g]),
      .accepted (acc_cnt[g]),
      .lost     (lost_cnt[g]),
      .state    (ch_state)
    );

    assign dbg_state[2*g +: 2] = ch_state;
  end

  assign sel_wide = 32'(cnt_sel);

  // Counter select: even codes pick accepted[n], odd pick lost[n]; out-of-range reads 0.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_wide == 32'(2 * i))     sel_val = acc_cnt[i];
      if (sel_wide == 32'(2 * i + 1)) sel_val = lost_cnt[i];
    end
  end

  // Register the selected counter so the readback path is a clean flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_out <= '0;
    else        cnt_out <= sel_val;
  end

endmodule

// File: tb/tb_random_pulser_array.sv
// Bench for random_pulser_array: two instances (16-bit and 4-bit counters)
// share one randomized stimulus stream; a reference model predicts every
// output each cycle into a queue that a negedge monitor drains and compares.
module tb_random_pulser_array;

  localparam int CH = 3;
  localparam int TW = 8;
  localparam int PL = 10;
  localparam int DT = 4;
  localparam int EXP_W = 2 * CH + 20;
`ifdef RANDOM_PULSER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              enable = 1'b1;
  logic [CH*TW-1:0]  thresh = '0;
  logic              count_clr = 1'b0;
  logic [2:0]        cnt_sel = '0;
  logic [CH-1:0]     pulse_a, pout_a, pulse_b, pout_b;
  logic [15:0]       cnt_a;
  logic [3:0]        cnt_b;
  logic [2*CH-1:0]   dbg_a, dbg_b;

  random_pulser_array #(.CHANNELS(CH), .THRESH_WIDTH(TW), .PULSE_LEN(PL), .DEAD_TIME(DT),
                        .COUNT_WIDTH(16), .SEED_BASE(16'hACE1)) dut_a (
    .clk(clk), .reset(rst_n), .enable(enable), .thresh(thresh), .count_clr(count_clr),
    .cnt_sel(cnt_sel), .pulse(pulse_a), .pout(pout_a), .cnt_out(cnt_a), .dbg_state(dbg_a));

  random_pulser_array #(.CHANNELS(CH), .THRESH_WIDTH(TW), .PULSE_LEN(PL), .DEAD_TIME(DT),
                        .COUNT_WIDTH(4), .SEED_BASE(16'hACE1)) dut_b (
    .clk(clk), .reset(rst_n), .enable(enable), .thresh(thresh), .count_clr(count_clr),
    .cnt_sel(cnt_sel), .pulse(pulse_b), .pout(pout_b), .cnt_out(cnt_b), .dbg_state(dbg_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Oneshot is modelled as time windows: an accepted strobe seen at edge e
  // holds pout for edges [e, e+PL) and blocks new accepts until edge e+PL+DT+1.
  logic [15:0]  m_lfsr [CH];
  logic         m_pulse[CH];
  longint       m_end  [CH];
  longint       m_free [CH];
  int unsigned  m_acc  [CH];
  int unsigned  m_lost [CH];
  longint       edge_n = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [15:0] seed_of(input int n);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(n * 32'h1F35);
    if (s == 16'h0) s = 16'h0001;
    return s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int unsigned sel_count(input logic [2:0] sel);
    int s;
    s = int'(sel);
    if (s >= 2 * CH) return 0;
    return (s % 2 == 1) ? m_lost[s / 2] : m_acc[s / 2];
  endfunction

  always @(posedge clk) begin : model
    logic [CH-1:0] ep, eo;
    logic [15:0]   e16;
    logic [3:0]    e4;
    int unsigned   v;
    edge_n++;
    ep = '0; eo = '0; e16 = '0; e4 = '0;
    if (!rst_n) begin
      for (int n = 0; n < CH; n++) begin
        m_lfsr[n] = seed_of(n); m_pulse[n] = 1'b0;
        m_end[n] = -1; m_free[n] = 0; m_acc[n] = 0; m_lost[n] = 0;
      end
    end else begin
      v   = sel_count(cnt_sel);
      e16 = (v > 65535) ? 16'hFFFF : 16'(v);
      e4  = (v > 15) ? 4'hF : 4'(v);
      for (int n = 0; n < CH; n++) begin
        if (m_pulse[n]) begin
          if (edge_n >= m_free[n] || (RETRIG && edge_n <= m_end[n])) begin
            m_end[n]  = edge_n + PL;
            m_free[n] = edge_n + PL + DT + 1;
            if (!count_clr) m_acc[n]++;
          end else if (!count_clr) begin
            m_lost[n]++;
          end
        end
        if (count_clr) begin m_acc[n] = 0; m_lost[n] = 0; end
        eo[n] = (edge_n < m_end[n]);
        ep[n] = enable && (m_lfsr[n][15:8] < thresh[n*TW +: TW]);
        if (enable) m_lfsr[n] = lfsr_step(m_lfsr[n]);
        m_pulse[n] = ep[n];
      end
    end
    exp_q.push_back({ep, eo, e16, e4});
  end

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pulse_a", 32'(pulse_a), 32'(mon_e[25:23]));
      check("pout_a",  32'(pout_a),  32'(mon_e[22:20]));
      check("cnt_a",   32'(cnt_a),   32'(mon_e[19:4]));
      check("pulse_b", 32'(pulse_b), 32'(mon_e[25:23]));
      check("pout_b",  32'(pout_b),  32'(mon_e[22:20]));
      check("cnt_b",   32'(cnt_b),   32'(mon_e[3:0]));
    end
  end

  // ---------------- pout0 run/gap checker ----------------
  bit chk_on = 1'b0;
  bit in_run = 1'b0, seen_fall = 1'b0, prev_p = 1'b0;
  int run_len = 0, gap_len = 0;
  always @(negedge clk) begin
    if (!chk_on) begin
      in_run = 1'b0; seen_fall = 1'b0;
    end else if (pout_a[0] && !prev_p) begin
      if (seen_fall) check("gap_min", 32'(gap_len >= DT + 1), 32'd1);
      in_run = 1'b1; run_len = 1;
    end else if (pout_a[0]) begin
      run_len++;
    end else if (prev_p) begin
`ifndef RANDOM_PULSER_RETRIGGER_EN
      if (in_run) check("run_len", 32'(run_len), 32'(PL));
`endif
      in_run = 1'b0; seen_fall = 1'b1; gap_len = 1;
    end else begin
      gap_len++;
    end
    prev_p = pout_a[0];
  end

  // ---------------- driver tasks ----------------
  task automatic rand_step(input int clr_odds, input bit rand_ch0);
    for (int n = (rand_ch0 ? 0 : 1); n < CH; n++) thresh[n*TW +: TW] = 8'($urandom_range(0, 255));
    cnt_sel   = 3'($urandom_range(0, 7));
    count_clr = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
    @(negedge clk);
  endtask

  task automatic wait_pout0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (pout_a[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  int activity;
  bit ok;

  initial begin
    // Reset held with enable high: everything must read zero.
    enable = 1'b1;
    thresh = '0;
    repeat (5) @(negedge clk);
    check("rst_pulse", 32'(pulse_a), 32'd0);
    check("rst_pout",  32'(pout_a),  32'd0);
    check("rst_cnt",   32'(cnt_a),   32'd0);
    rst_n = 1'b1;

    // Channel 0 never fires with threshold 0; others run randomly.
    activity = 0;
    for (int i = 0; i < 10000; i++) begin
      rand_step(64, 1'b0);
      if (pulse_a[0] || pout_a[0]) activity++;
    end
    check("ch0_silent", 32'(activity), 32'd0);

    // Channel 0 at maximum rate: runs of PL, gaps of at least DT.
    thresh[0 +: TW] = 8'd255;
    count_clr = 1'b0;
    chk_on = 1'b1;
    for (int i = 0; i < 2000; i++) rand_step(0, 1'b0);
    chk_on = 1'b0;

    // Freeze channel 0 and read its counters directly (4-bit one saturated).
    thresh[0 +: TW] = 8'd0;
    repeat (20) @(negedge clk);
    cnt_sel = 3'd0;
    repeat (2) @(negedge clk);
    check("sat_acc_b", 32'(cnt_b), (m_acc[0] > 15) ? 32'd15 : 32'(m_acc[0]));
    check("acc_a",     32'(cnt_a), 32'(m_acc[0]));
    cnt_sel = 3'd6;
    repeat (2) @(negedge clk);
    check("sel_oob", 32'(cnt_a), 32'd0);

    // Clears landing on top of hits.
    thresh = '1;
    for (int i = 0; i < 300; i++) rand_step(5, 1'b0);
    count_clr = 1'b0;

    // Enable dropped mid-pulse: pout completes, no new strobes.
    thresh[0 +: TW] = 8'd255;
    wait_pout0(ok);
    check("wait_pout0_en", 32'(ok), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    activity = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pulse_a != '0) activity++;
    end
    check("no_pulse_when_off", 32'(activity), 32'd0);
    enable = 1'b1;

    // Asynchronous reset mid-pulse drops pout without a clock edge.
    wait_pout0(ok);
    check("wait_pout0_rst", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_pout_a", 32'(pout_a), 32'd0);
    check("async_pout_b", 32'(pout_b), 32'd0);
    check("async_cnt",    32'(cnt_a),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Two strobes three cycles apart on channel 0.
    thresh = '0;
    repeat (30) @(negedge clk);
    thresh[0 +: TW] = 8'd255; @(negedge clk);
    thresh[0 +: TW] = 8'd0;   repeat (2) @(negedge clk);
    thresh[0 +: TW] = 8'd255; @(negedge clk);
    thresh[0 +: TW] = 8'd0;
    cnt_sel = 3'd0; repeat (25) @(negedge clk);
    cnt_sel = 3'd1; repeat (3) @(negedge clk);

    // Free-running random mix.
    for (int i = 0; i < 2000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      rand_step(100, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/random_pulser_array.md
Name: random_pulser_array

Overview:
Multi-channel pseudo-random pulse generator. It is the parametrised successor of the single random/oneshot pair used in the mixer top. Each of CHANNELS channels has its own 16-bit LFSR and an 8-bit rate threshold (normally the encoder value). Each channel also has a oneshot with a dead-time, plus saturating accepted/lost event counters readable through a select mux. It sits between the encoders and the output pins, replacing per-channel random and oneshot instances.

Parameters:
CHANNELS, 4, number of independent channels (1..8)
THRESH_WIDTH, 8, threshold width; compared against LFSR[15:16-THRESH_WIDTH]
PULSE_LEN, 10, pout high time in clk cycles (>=1)
DEAD_TIME, 4, post-pulse dead cycles in which triggers are rejected (>=0)
COUNT_WIDTH, 16, width of each event counter
SEED_BASE, 16'hACE1, channel n seed = SEED_BASE ^ (n*16'h1F35); forced to 16'h0001 if the result is zero

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  global run; LFSRs advance and triggers are evaluated only while high
thresh  input  CHANNELS*THRESH_WIDTH  per-channel rate; channel n uses bits [n*THRESH_WIDTH +: THRESH_WIDTH]
count_clr  input  1  synchronous clear of all counters
cnt_sel  input  $clog2(2*CHANNELS)  counter select: even = accepted[n], odd = lost[n], n = cnt_sel>>1
pulse  output  CHANNELS  registered raw trigger, one cycle per hit
pout  output  CHANNELS  stretched oneshot output
cnt_out  output  COUNT_WIDTH  registered selected counter

Behaviour:
- Reset (reset=0, async): LFSRs load their seeds; pulse, pout, and cnt_out go to 0; all FSMs go to IDLE; all counters go to 0.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1, advances one step per cycle while enable=1 and holds otherwise. It is maximal-length, so all-zero is unreachable.
- Hit: hit_n = enable & (LFSR_n[15:16-THRESH_WIDTH] < thresh_n). pulse_n is registered from hit_n, giving 1 cycle latency. Hit probability is thresh/2^THRESH_WIDTH. thresh=0 means never; thresh=255 means 255/256.
- Per-channel FSM, driven from the registered pulse_n:
  - IDLE: if pulse_n, go to ACTIVE, load timer=PULSE_LEN-1, and increment accepted_n.
  - ACTIVE: pout_n=1. Decrement timer; at 0, go to DEAD (timer=DEAD_TIME-1), or to IDLE if DEAD_TIME=0. A pulse_n arriving here increments lost_n.
  - DEAD: pout_n=0. Decrement timer; at 0, go to IDLE. A pulse_n arriving here increments lost_n.
- Timing: pout_n rises the cycle after an accepted pulse_n and is high for exactly PULSE_LEN cycles. A pulse_n in the last DEAD cycle counts as lost. A pulse_n in the first IDLE cycle is accepted.
- enable falling mid-pulse: the FSM completes ACTIVE/DEAD normally; only new hits stop.
- Counters saturate at all-ones and do not wrap.
- count_clr has priority over a simultaneous increment: the result is 0 and that event is not counted.
- cnt_out is registered, 1 cycle after cnt_sel/counter change. A cnt_sel value >= 2*CHANNELS returns 0.
- Async reset mid-ACTIVE drops pout immediately.

Optional Feature:
RANDOM_PULSER_RETRIGGER_EN:
- Defined: a pulse_n during ACTIVE reloads timer=PULSE_LEN-1 (extends pout) and increments accepted_n, not lost_n. Behaviour during DEAD is unchanged.
- Undefined: behaviour is exactly as above.

Decomposition:
- Package random_pulser_pkg holds:
  - the FSM state typedef (IDLE/ACTIVE/DEAD);
  - LFSR_WIDTH=16 and the LFSR tap mask constant;
  - the seed-derivation function.
- One natural sub-module, pulser_channel: LFSR, compare, FSM, and two counters, instantiated CHANNELS times via generate. The top holds the thresh slicing and the cnt_sel mux.

Test Plan:
- Reset values: hold reset=0 with enable=1 -> pulse, pout, and cnt_out are all 0. Release reset -> LFSR0 first value follows from seed 16'hACE1 per the golden model.
- thresh0=0 with enable=1 for 10000 cycles -> pulse0=0, pout0=0, and accepted0=lost0=0 throughout.
- thresh0=255, PULSE_LEN=10, DEAD_TIME=4, 2000 cycles:
  - every pout0 high run is exactly 10 cycles;
  - low gaps are >=4 cycles;
  - accepted0 + lost0 equals the pulse0 count from the golden LFSR model.
- Saturation and clear, with COUNT_WIDTH=4 and thresh=255:
  - accepted saturates at 15;
  - count_clr asserted in the same cycle as a hit -> cnt_out reads 0 two cycles later;
  - cnt_sel=2*CHANNELS -> 0.
- Mid-operation events:
  - enable dropped during ACTIVE -> pout finishes its 10 cycles and no new pulses occur;
  - async reset asserted mid-ACTIVE -> pout falls with no clock edge.
- With RANDOM_PULSER_RETRIGGER_EN, force back-to-back hits 3 cycles apart -> pout stays high 3+10 cycles, accepted increments by 2, and lost is 0.
